blanket_0: RTL and testbench
============================

Name: blanket_0

Overview:
- Blanket-0 background pattern generator for the BIST controller of a 256x4 SRAM.
- When enabled, sweeps every address once in ascending or descending order.
- Drives the all-zeros data word and a write enable on each address, then flags completion.
- Sits between the BIST sequencer (drives en_in/rev_in) and the SRAM port mux (consumes addr/data/w_en).

Parameters:
- ADDR_W, 8, address width; sweep covers 2**ADDR_W locations.
- DATA_W, 4, data word width.
- PATTERN, 0 (DATA_W bits), background word written to every location.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- en_in  input  1  sweep enable; level-sensitive.
- rev_in  input  1  address order select: 0 = ascending, 1 = descending; sampled only at sweep start.
- dat_out  output  DATA_W  write data to SRAM; constant PATTERN.
- addr_out  output  ADDR_W  SRAM address.
- w_en_out  output  1  SRAM write enable, active-high.
- rst_done  output  1  sweep complete flag; held high until en_in drops.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - state=IDLE, addr_out=0, w_en_out=0, rst_done=0, internal direction register=0.
  - Reset overrides all other inputs, including mid-sweep.
- dat_out is always PATTERN, including during reset and in every state.
- States: IDLE, RUN, DONE; all outputs registered.
- IDLE:
  - Outputs: w_en_out=0, rst_done=0, addr_out=0.
  - On an edge with en_in=1: enter RUN, latch dir=rev_in, load addr_out = 0 (dir=0) or 2**ADDR_W-1 (dir=1), set w_en_out=1.
  - The first write address is therefore visible one cycle after en_in is sampled high.
- RUN:
  - w_en_out=1; each edge advances addr_out by +1 (dir=0) or -1 (dir=1).
  - rev_in changes during RUN are ignored.
  - Exactly 2**ADDR_W cycles have w_en_out=1, one per address, no repeats or skips.
  - The end address is 2**ADDR_W-1 (dir=0) or 0 (dir=1).
  - Edge while addr_out equals the end address: enter DONE; addr_out holds the end address (no wrap); w_en_out=0; rst_done=1.
  - en_in=0 sampled in RUN: abort to IDLE next edge; addr_out=0, w_en_out=0, rst_done=0.
- DONE:
  - rst_done=1, w_en_out=0, addr_out holds.
  - Stays in DONE while en_in=1; no re-sweep without en_in first going low.
  - en_in=0: go to IDLE next edge; rst_done clears.
- Simultaneous events:
  - Reset has priority over everything.
  - In RUN, en_in=0 has priority over completion: abort, rst_done is not set.
- Minimum restart: en_in low for one sampled edge, then high starts a fresh sweep using the newly sampled rev_in.

Decomposition:
- Shared package bist_pkg holds:
  - state enum (IDLE/RUN/DONE)
  - default ADDR_W=8 and DATA_W=4 constants
  - first/last address helper constants
- One sub-module: bist_addr_ctr. It is a loadable up/down counter with ADDR_W width, load value, direction and terminal-count output, and is reused by the other BIST pattern generators.
- blanket_0 holds the FSM and output registers.

Test Plan:
- Reset: rst_n=0 for 2 cycles with en_in=1 -> addr_out=0, w_en_out=0, rst_done=0, dat_out=4'h0.
- Ascending sweep: rev_in=0, en_in=1 held -> addr_out 0..255 on 256 consecutive cycles with w_en_out=1 and dat_out=0; next cycle rst_done=1, w_en_out=0, addr_out=255, held while en_in=1.
- Descending sweep: after en_in low one cycle, rev_in=1, en_in=1 -> addr_out 255..0 over 256 cycles; then rst_done=1 with addr_out=0.
- rev_in toggled mid-sweep (ascending, flip at addr 100) -> order unchanged; 256 unique addresses written.
- Abort: en_in dropped at addr 37 -> next cycle state IDLE, addr_out=0, w_en_out=0, rst_done never asserted. Re-enable -> sweep restarts at 0.
- Reset mid-sweep at addr 200 (rst_n=0) -> next edge all outputs at reset values; sweep restarts from 0 after release with en_in=1.

Source files
------------

// File: rtl/bist_pkg.sv
// Shared definitions for the BIST pattern generators: sweep states,
// default SRAM geometry and sweep endpoint constants.
package bist_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } bist_state_e;

    localparam int BIST_ADDR_W = 8;
    localparam int BIST_DATA_W = 4;

    // Endpoints of a sweep for the default address width.
    localparam logic [BIST_ADDR_W-1:0] BIST_ADDR_FIRST = '0;
    localparam logic [BIST_ADDR_W-1:0] BIST_ADDR_LAST  = '1;

endpackage

// File: rtl/bist_addr_ctr.sv
// Loadable up/down address counter shared by the BIST pattern generators.
// tc_o flags the terminal address for the current direction.
module bist_addr_ctr #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         step_i,
    input  logic         dir_i,
    output logic [W-1:0] cnt_o,
    output logic         tc_o
);

    localparam logic [W-1:0] CNT_MIN = '0;
    localparam logic [W-1:0] CNT_MAX = '1;

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Load wins over step; dir_i=1 counts down.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (step_i) begin
            cnt_d = dir_i ? (cnt_q - 1'b1) : (cnt_q + 1'b1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign tc_o  = (cnt_q == (dir_i ? CNT_MIN : CNT_MAX));

endmodule

// File: rtl/blanket_0.sv
// Blanket-0 background generator: writes PATTERN to every SRAM address once,
// ascending or descending, then holds rst_done until en_in drops.
module blanket_0
    import bist_pkg::*;
#(
    parameter int                ADDR_W  = BIST_ADDR_W,
    parameter int                DATA_W  = BIST_DATA_W,
    parameter logic [DATA_W-1:0] PATTERN = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_in,
    input  logic              rev_in,
    output logic [DATA_W-1:0] dat_out,
    output logic [ADDR_W-1:0] addr_out,
    output logic              w_en_out,
    output logic              rst_done
);

    localparam logic [ADDR_W-1:0] ADDR_FIRST = '0;
    localparam logic [ADDR_W-1:0] ADDR_LAST  = '1;

    bist_state_e state_q, state_d;
    logic        dir_q, dir_d;
    logic        w_en_q, w_en_d;
    logic        done_q, done_d;

    logic              ctr_load;
    logic [ADDR_W-1:0] ctr_load_val;
    logic              ctr_step;
    logic              ctr_tc;

    bist_addr_ctr #(
        .W(ADDR_W)
    ) u_addr_ctr (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (ctr_load),
        .load_val_i (ctr_load_val),
        .step_i     (ctr_step),
        .dir_i      (dir_q),
        .cnt_o      (addr_out),
        .tc_o       (ctr_tc)
    );

    // Dropping en_in during RUN beats completion, so an abort never flags done.
    always_comb begin
        state_d      = state_q;
        dir_d        = dir_q;
        w_en_d       = 1'b0;
        done_d       = 1'b0;
        ctr_load     = 1'b0;
        ctr_load_val = ADDR_FIRST;
        ctr_step     = 1'b0;
        unique case (state_q)
            IDLE: begin
                ctr_load = 1'b1;
                if (en_in) begin
                    state_d      = RUN;
                    dir_d        = rev_in;
                    w_en_d       = 1'b1;
                    ctr_load_val = rev_in ? ADDR_LAST : ADDR_FIRST;
                end
            end
            RUN: begin
                if (!en_in) begin
                    state_d  = IDLE;
                    ctr_load = 1'b1;
                end else if (ctr_tc) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    w_en_d   = 1'b1;
                    ctr_step = 1'b1;
                end
            end
            DONE: begin
                if (!en_in) begin
                    state_d  = IDLE;
                    ctr_load = 1'b1;
                end else begin
                    done_d = 1'b1;
                end
            end
            default: begin
                state_d  = IDLE;
                ctr_load = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            dir_q   <= 1'b0;
            w_en_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            w_en_q  <= w_en_d;
            done_q  <= done_d;
        end
    end

    assign dat_out  = PATTERN;
    assign w_en_out = w_en_q;
    assign rst_done = done_q;

endmodule

// File: tb/tb_blanket_0.sv
// Self-checking bench for blanket_0: directed sweep scenarios followed by
// randomized enable/direction/reset traffic against a sweep-position model.
module tb_blanket_0;

    localparam int NADDR = 256;

    logic       clk;
    logic       rst_n;
    logic       en_in;
    logic       rev_in;
    logic [3:0] dat_out;
    logic [7:0] addr_out;
    logic       w_en_out;
    logic       rst_done;

    int vecCount  = 0;
    int failCount = 0;

    // Reference model: a sweep is a position 0..255 plus a direction.
    bit sweeping = 1'b0;
    bit finished = 1'b0;
    bit sweepRev = 1'b0;
    int sweepPos = 0;
    int finishedAddr = 0;

    bit written[NADDR];
    int uniqCount = 0;

    blanket_0 dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en_in    (en_in),
        .rev_in   (rev_in),
        .dat_out  (dat_out),
        .addr_out (addr_out),
        .w_en_out (w_en_out),
        .rst_done (rst_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        vecCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    task automatic clearScoreboard();
        for (int i = 0; i < NADDR; i++) written[i] = 1'b0;
        uniqCount = 0;
    endtask

    // Advance the model by one sampled edge using the inputs just applied.
    task automatic modelEdge(input bit r, input bit e, input bit v);
        bit justFinished = 1'b0;
        if (!r) begin
            sweeping = 1'b0;
            finished = 1'b0;
            clearScoreboard();
        end else if (sweeping) begin
            if (!e) begin
                sweeping = 1'b0;
                clearScoreboard();
            end else if (sweepPos == NADDR - 1) begin
                sweeping     = 1'b0;
                finished     = 1'b1;
                finishedAddr = sweepRev ? 0 : NADDR - 1;
                justFinished = 1'b1;
            end else begin
                sweepPos++;
            end
        end else if (finished) begin
            if (!e) finished = 1'b0;
        end else if (e) begin
            sweeping = 1'b1;
            sweepRev = v;
            sweepPos = 0;
            clearScoreboard();
        end
        if (justFinished) checkOutput("uniqueAddrs", uniqCount, NADDR);
    endtask

    // One cycle: drive on the falling edge, sample 1ns after the rising edge.
    task automatic applyStimulus(input bit r, input bit e, input bit v);
        int expAddr;
        @(negedge clk);
        rst_n  = r;
        en_in  = e;
        rev_in = v;
        @(posedge clk);
        modelEdge(r, e, v);
        #1;
        if (sweeping)      expAddr = sweepRev ? (NADDR - 1 - sweepPos) : sweepPos;
        else if (finished) expAddr = finishedAddr;
        else               expAddr = 0;
        checkOutput("addr_out", int'(addr_out), expAddr);
        checkOutput("w_en_out", int'(w_en_out), int'(sweeping));
        checkOutput("rst_done", int'(rst_done), int'(finished));
        checkOutput("dat_out",  int'(dat_out), 0);
        if (w_en_out === 1'b1 && !written[addr_out]) begin
            written[addr_out] = 1'b1;
            uniqCount++;
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        en_in  = 1'b1;
        rev_in = 1'b0;

        // Reset held with en_in high.
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("resetAddr", int'(addr_out), 0);

        // Ascending sweep, then a few cycles parked in done.
        for (int i = 0; i < NADDR + 4; i++) applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("ascDoneAddr", int'(addr_out), NADDR - 1);

        // Descending sweep after one low cycle.
        applyStimulus(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < NADDR + 3; i++) applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("descDoneAddr", int'(addr_out), 0);

        // Ascending sweep with rev_in flipped partway through.
        applyStimulus(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < NADDR + 3; i++) applyStimulus(1'b1, 1'b1, (i > 100));

        // Abort at address 37, then restart.
        applyStimulus(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 38; i++) applyStimulus(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 1'b0);

        // Reset in the middle of a fresh sweep at address 200.
        applyStimulus(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 201; i++) applyStimulus(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b1, 1'b0);

        // Randomized traffic: rare enable drops and resets, noisy rev_in.
        for (int i = 0; i < 4000; i++) begin
            bit r, e, v;
            r = ($urandom_range(0, 511) != 0);
            e = ($urandom_range(0, 99) != 0);
            v = 1'($urandom_range(0, 1));
            applyStimulus(r, e, v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, failCount);
        $finish;
    end

endmodule
